// File: rtl/mdio_pkg.sv
// Shared types and frame-field constants for the MDIO management master.
// Frame legality depends on MDIO_CL45_EN (Clause 45 ST=00 frames accepted when defined).
package mdio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_HEADER,
    S_TA,
    S_DATA,
    S_DONE
  } mdio_state_e;

  localparam logic [1:0] ST_CL22 = 2'b01;
  localparam logic [1:0] ST_CL45 = 2'b00;

  localparam logic [1:0] OP_WRITE      = 2'b01;
  localparam logic [1:0] OP_READ       = 2'b10;
  localparam logic [1:0] OP_C45_READ   = 2'b11;
  localparam logic [1:0] OP_C45_RD_INC = 2'b10;

  // Bit positions inside t_data
  localparam int unsigned ST_MSB    = 31;
  localparam int unsigned OP_MSB    = 29;
  localparam int unsigned HDR_MSB   = 31;
  localparam int unsigned HDR_LSB   = 18;
  localparam int unsigned TA_MSB    = 17;
  localparam int unsigned WDATA_MSB = 15;

  localparam int unsigned HEADER_BITS = 14;
  localparam int unsigned TA_BITS     = 2;
  localparam int unsigned DATA_BITS   = 16;

  function automatic logic frame_valid(input logic [1:0] st, input logic [1:0] op);
`ifdef MDIO_CL45_EN
    return (st == ST_CL45) || ((st == ST_CL22) && ((op == OP_WRITE) || (op == OP_READ)));
`else
    return (st == ST_CL22) && ((op == OP_WRITE) || (op == OP_READ));
`endif
  endfunction

  // Only meaningful for frames that passed frame_valid
  function automatic logic frame_is_read(input logic [1:0] st, input logic [1:0] op);
    if (st == ST_CL45) return (op == OP_C45_READ) || (op == OP_C45_RD_INC);
    return op == OP_READ;
  endfunction

endpackage

// File: rtl/mdio_mdc_gen.sv
// MDC divider: CLK_DIV/2 cycles low then CLK_DIV/2 high, with strobes flagging
// the clk edges on which MDC falls (next bit driven) and rises (mdio_in sampled).
module mdio_mdc_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mdc,
  output logic mdc_fall_c,
  output logic mdc_rise_c
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLK_DIV / 2);
  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV / 2 - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  always_comb begin
    cnt_next = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
  end

  assign mdc_fall_c = en && (cnt == CNT_LAST);
  assign mdc_rise_c = en && (cnt == CNT_RISE);

  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt <= '0;
      mdc <= 1'b0;
    end else begin
      cnt <= cnt_next;
      mdc <= (cnt_next >= CNT_HALF);
    end
  end

endmodule

// File: rtl/mdio_master.sv
// IEEE 802.3 MDIO management master: preamble, header, turnaround and data
// phases with read capture. Build macro MDIO_CL45_EN adds Clause 45 frames.
module mdio_master
  import mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 4,
  parameter int unsigned PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdio_start,
  input  logic [31:0] t_data,
  input  logic        mdio_in,
  output logic        mdc,
  output logic        mdio_out,
  output logic        mdio_oe,
  output logic [15:0] rd_data,
  output logic        data_valid,
  output logic        mdio_done,
  output logic        err,
  output logic        busy
);

  localparam int unsigned CNT_MAX = (PREAMBLE_LEN > DATA_BITS) ? PREAMBLE_LEN : DATA_BITS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HEADER_BITS - 1);
  localparam logic [CNT_W-1:0] TA_LAST   = CNT_W'(TA_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);

  mdio_state_e      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [31:0]      tx_sr;
  logic [15:0]      rx_sr;
  logic             is_read;
  logic             rejected;
  logic             mdc_en;
  logic             mdc_fall_c;
  logic             mdc_rise_c;
  logic             start_valid;
  logic             start_read;
  logic [31:0]      start_frame;
  logic             ta_unused;

  assign start_valid = frame_valid(t_data[ST_MSB -: 2], t_data[OP_MSB -: 2]);
  assign start_read  = frame_is_read(t_data[ST_MSB -: 2], t_data[OP_MSB -: 2]);
  // TA is always driven '1','0' on writes; the caller's TA field is ignored
  assign start_frame = {t_data[HDR_MSB:HDR_LSB], 2'b10, t_data[WDATA_MSB:0]};
  assign ta_unused   = ^t_data[TA_MSB -: 2];
  assign mdc_en      = (state == S_PREAMBLE) || (state == S_HEADER) ||
                       (state == S_TA) || (state == S_DATA);

  mdio_mdc_gen #(.CLK_DIV(CLK_DIV)) u_mdc_gen (
    .clk        (clk),
    .reset      (reset),
    .en         (mdc_en),
    .mdc        (mdc),
    .mdc_fall_c (mdc_fall_c),
    .mdc_rise_c (mdc_rise_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      is_read    <= 1'b0;
      rejected   <= 1'b0;
      mdio_out   <= 1'b1;
      mdio_oe    <= 1'b0;
      rd_data    <= '0;
      data_valid <= 1'b0;
      mdio_done  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      mdio_done  <= 1'b0;
      err        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mdio_start) begin
            busy    <= 1'b1;
            bit_cnt <= '0;
            is_read <= start_read;
            if (!start_valid) begin
              rejected <= 1'b1;
              state    <= S_DONE;
            end else begin
              rejected <= 1'b0;
              mdio_oe  <= 1'b1;
              if (PREAMBLE_LEN == 0) begin
                state    <= S_HEADER;
                mdio_out <= start_frame[31];
                tx_sr    <= {start_frame[30:0], 1'b0};
              end else begin
                state    <= S_PREAMBLE;
                mdio_out <= 1'b1;
                tx_sr    <= start_frame;
              end
            end
          end
        end
        S_PREAMBLE: begin
          if (mdc_fall_c) begin
            if (bit_cnt == PRE_LAST) begin
              state    <= S_HEADER;
              bit_cnt  <= '0;
              mdio_out <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_HEADER: begin
          if (mdc_fall_c) begin
            mdio_out <= tx_sr[31];
            tx_sr    <= {tx_sr[30:0], 1'b0};
            if (bit_cnt == HDR_LAST) begin
              state   <= S_TA;
              bit_cnt <= '0;
              mdio_oe <= !is_read;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_TA: begin
          if (mdc_fall_c) begin
            mdio_out <= tx_sr[31];
            tx_sr    <= {tx_sr[30:0], 1'b0};
            if (bit_cnt == TA_LAST) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        S_DATA: begin
          if (mdc_rise_c) rx_sr <= {rx_sr[14:0], mdio_in};
          if (mdc_fall_c) begin
            if (bit_cnt == DATA_LAST) begin
              state    <= S_DONE;
              mdio_out <= 1'b1;
              mdio_oe  <= 1'b0;
            end else begin
              bit_cnt  <= bit_cnt + CNT_W'(1);
              mdio_out <= tx_sr[31];
              tx_sr    <= {tx_sr[30:0], 1'b0};
            end
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          mdio_done <= 1'b1;
          err       <= rejected;
          if (is_read && !rejected) begin
            rd_data    <= rx_sr;
            data_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
